// File: rtl/peak_alarm_pkg.sv
// peak_alarm shared types: 2-bit FSM state type and encodings,
// plus the saturating magnitude helper used by the optional ABS mode.
package peak_alarm_pkg;

  typedef logic [1:0] pa_state_t;

  localparam logic [1:0] PA_IDLE    = 2'd0;
  localparam logic [1:0] PA_PENDING = 2'd1;
  localparam logic [1:0] PA_ALARM   = 2'd2;
  localparam logic [1:0] PA_HOLD    = 2'd3;

  // -32768 has no positive twin; clamp so the result stays signed 16-bit.
  function automatic logic signed [15:0] abs_sat(
    input logic signed [15:0] v
  );
    if (v == 16'sh8000)
      return 16'sh7fff;
    else if (v < 0)
      return -v;
    else
      return v;
  endfunction

endpackage

// File: rtl/peak_alarm_timer.sv
// Loadable up-counter shared by the debounce and hold phases.
// Ports: clk, rst (async low), clr, load/val, inc, term -> cnt, hit.
module peak_alarm_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] val,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         hit
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (load)
      cnt <= val;
    else if (inc)
      cnt <= cnt + 1'b1;
  end

  assign hit = (cnt == term);

endmodule

// File: rtl/peak_alarm.sv
// Debounced peak alarm with hysteresis, hold time and event counter.
// Ports: clk, rst (async low), in (s16) -> alarm, state, events.
// Macro PEAK_ALARM_ABS_EN: compare |in| instead of signed in.
// EV_MAX sets the events saturation point (default 16'hFFFF).
module peak_alarm
  import peak_alarm_pkg::*;
#(
  parameter logic signed [15:0] HI_TH    = 16'sd12000,
  parameter logic signed [15:0] LO_TH    = 16'sd8000,
  parameter int                 DEBOUNCE = 16,
  parameter int                 HOLD     = 3000,
  parameter logic [15:0]        EV_MAX   = 16'hffff
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] in,
  output logic               alarm,
  output logic [1:0]         state,
  output logic [15:0]        events
);

  localparam int CMAX = (DEBOUNCE > HOLD) ? DEBOUNCE : HOLD;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] D_TERM = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] H_TERM = CW'(HOLD - 1);

  logic signed [15:0] mag;
  logic               hi;
  logic               lo;
  pa_state_t          state_q;
  pa_state_t          nxt;
  logic               clr;
  logic               load;
  logic               inc;
  logic               enter;
  logic [CW-1:0]      term;
  logic [CW-1:0]      cnt;
  logic               hit;

`ifdef PEAK_ALARM_ABS_EN
  assign mag = abs_sat(in);
`else
  assign mag = in;
`endif

  assign hi = (mag >= HI_TH);
  assign lo = (mag <= LO_TH);

  // Only PENDING and HOLD consult the terminal compare.
  assign term = (state_q == PA_PENDING) ? D_TERM : H_TERM;

  always_comb begin
    nxt   = state_q;
    clr   = 1'b0;
    load  = 1'b0;
    inc   = 1'b0;
    enter = 1'b0;
    unique case (state_q)
      PA_IDLE: begin
        if (hi) begin
          if (DEBOUNCE == 1) begin
            nxt   = PA_ALARM;
            enter = 1'b1;
          end else begin
            nxt  = PA_PENDING;
            load = 1'b1;
          end
        end
      end
      PA_PENDING: begin
        if (!hi) begin
          nxt = PA_IDLE;
          clr = 1'b1;
        end else if (hit) begin
          nxt   = PA_ALARM;
          enter = 1'b1;
        end else begin
          inc = 1'b1;
        end
      end
      PA_ALARM: begin
        if (lo) begin
          nxt = PA_HOLD;
          clr = 1'b1;
        end
      end
      PA_HOLD: begin
        if (hi)
          nxt = PA_ALARM;
        else if (hit)
          nxt = PA_IDLE;
        else
          inc = 1'b1;
      end
    endcase
  end

  peak_alarm_timer #(
    .W(CW)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .load (load),
    .val  (CW'(1)),
    .inc  (inc),
    .term (term),
    .cnt  (cnt),
    .hit  (hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= PA_IDLE;
      alarm   <= 1'b0;
      events  <= '0;
    end else begin
      state_q <= nxt;
      alarm   <= (nxt == PA_ALARM) || (nxt == PA_HOLD);
      if (enter && events != EV_MAX)
        events <= events + 16'd1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_peak_alarm.sv
// Testbench for peak_alarm: directed vector table, async reset,
// event saturation (small EV_MAX instance) and random vs. model.
module tb_peak_alarm;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic signed [15:0] in0 = '0;
  logic signed [15:0] in1 = '0;
  logic               alarm0;
  logic               alarm1;
  logic [1:0]         state0;
  logic [1:0]         state1;
  logic [15:0]        events0;
  logic [15:0]        events1;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  peak_alarm #(
    .HI_TH    (16'sd1000),
    .LO_TH    (16'sd500),
    .DEBOUNCE (4),
    .HOLD     (8)
  ) u0 (
    .clk    (clk),
    .rst    (rst),
    .in     (in0),
    .alarm  (alarm0),
    .state  (state0),
    .events (events0)
  );

  peak_alarm #(
    .HI_TH    (16'sd1000),
    .LO_TH    (16'sd500),
    .DEBOUNCE (1),
    .HOLD     (1),
    .EV_MAX   (16'd5)
  ) u1 (
    .clk    (clk),
    .rst    (rst),
    .in     (in1),
    .alarm  (alarm1),
    .state  (state1),
    .events (events1)
  );

  typedef struct {
    logic signed [15:0] din;
    logic [1:0]         st;
    logic [15:0]        ev;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int v, input int s, input int e, input int n);
    vec_t t;
    t.din = 16'(v);
    t.st  = 2'(s);
    t.ev  = 16'(e);
    repeat (n) tbl.push_back(t);
  endtask

  task automatic check(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: alarm condition tracked as a run length of
  // qualifying samples and a countdown of hold time remaining.
  int m_mode, m_run, m_left, m_ev;

  function automatic int mag(input int v);
`ifdef PEAK_ALARM_ABS_EN
    if (v == -32768) return 32767;
    return (v < 0) ? -v : v;
`else
    return v;
`endif
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_run  = 0;
    m_left = 0;
    m_ev   = 0;
  endtask

  task automatic model_step(input int v);
    bit hi, lo;
    hi = mag(v) >= 1000;
    lo = mag(v) <= 500;
    if (m_mode < 2) begin
      if (hi) begin
        m_run++;
        if (m_run >= 4) begin
          m_mode = 2;
          m_run  = 0;
          if (m_ev < 65535) m_ev++;
        end else begin
          m_mode = 1;
        end
      end else begin
        m_run  = 0;
        m_mode = 0;
      end
    end else if (m_mode == 2) begin
      if (lo) begin
        m_mode = 3;
        m_left = 8;
      end
    end else begin
      if (hi) begin
        m_mode = 2;
      end else begin
        m_left--;
        if (m_left == 0) m_mode = 0;
      end
    end
  endtask

  function automatic int pick();
    case ($urandom_range(0, 9))
      0: return 1000;
      1: return 999;
      2: return 500;
      3: return 501;
      4: return int'($urandom_range(1000, 4000));
      5: return int'($urandom_range(501, 999));
      6: return int'($urandom_range(0, 500));
      7: return -int'($urandom_range(0, 3000));
      8: return -32768;
      default: return 32767;
    endcase
  endfunction

  initial begin
    // Directed table, u0 (HI=1000 LO=500 DEB=4 HOLD=8)
    add(1200, 1, 0, 3);
    add(0,    0, 0, 1);
    add(1200, 1, 0, 3);
    add(1200, 2, 1, 1);
    add(700,  2, 1, 50);
    add(400,  3, 1, 1);
    add(0,    3, 1, 7);
    add(0,    0, 1, 1);
    add(1200, 1, 1, 3);
    add(1200, 2, 2, 1);
    add(400,  3, 2, 1);
    add(0,    3, 2, 5);
    add(1200, 2, 2, 1);
    add(0,    3, 2, 8);
    add(0,    0, 2, 1);
    add(999,  0, 2, 2);
    add(1000, 1, 2, 3);
    add(1000, 2, 3, 1);
    add(501,  2, 3, 3);
    add(500,  3, 3, 1);
    add(999,  3, 3, 7);
    add(999,  0, 3, 1);
`ifdef PEAK_ALARM_ABS_EN
    add(-1200,  1, 3, 3);
    add(-1200,  2, 4, 1);
    add(-32768, 2, 4, 2);
    add(0,      3, 4, 8);
    add(0,      0, 4, 1);
`else
    add(-1200,  0, 3, 4);
    add(-32768, 0, 3, 2);
`endif

    #12;
    check("reset_state", state0, 0);
    check("reset_alarm", alarm0, 0);
    check("reset_events", events0, 0);
    rst = 1'b1;

    foreach (tbl[i]) begin
      in0 = tbl[i].din;
      tick();
      check($sformatf("tbl%0d_state", i), state0, tbl[i].st);
      check($sformatf("tbl%0d_alarm", i), alarm0, int'(tbl[i].st >= 2));
      check($sformatf("tbl%0d_events", i), events0, tbl[i].ev);
    end

    // Async reset mid-HOLD, between clock edges.
    in0 = 1200;
    repeat (4) tick();
    check("pre_rst_state", state0, 2);
    in0 = 0;
    repeat (3) tick();
    check("pre_rst_hold", state0, 3);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_state", state0, 0);
    check("async_rst_alarm", alarm0, 0);
    check("async_rst_events", events0, 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // Saturation and DEBOUNCE==1 path on u1 (EV_MAX=5).
    for (int k = 0; k < 7; k++) begin
      in1 = 1200;
      tick();
      check("sat_state", state1, 2);
      check("sat_alarm", alarm1, 1);
      check("sat_events", events1, (k + 1 < 5) ? k + 1 : 5);
      in1 = 0;
      tick();
      check("sat_hold", state1, 3);
      tick();
      check("sat_idle", state1, 0);
    end

    // Randomized runs against the model; u0 idle with zero events.
    for (int r = 0; r < 600; r++) begin
      int v;
      v = pick();
      repeat ($urandom_range(1, 12)) begin
        in0 = 16'(v);
        @(posedge clk);
        model_step(v);
        #1;
        check("rnd_state", state0, m_mode);
        check("rnd_alarm", alarm0, int'(m_mode >= 2));
        check("rnd_events", events0, m_ev);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/peak_alarm.md
Name: peak_alarm

Overview:
- Downstream consumer of the PEAK detector output.
- Watches the signed 16-bit peak value and raises a debounced alarm with hysteresis between two thresholds.
- Holds the alarm for a minimum time after the level falls, and counts alarm events.
- Feeds status/interrupt logic; all outputs registered, single clock domain.

Parameters:
- HI_TH, 16'sd12000: signed assert threshold; compare is in >= HI_TH.
- LO_TH, 16'sd8000: signed release threshold; compare is in <= LO_TH. Must be < HI_TH.
- DEBOUNCE, 16: consecutive qualifying samples required to assert. Must be >= 1.
- HOLD, 3000: cycles the alarm stays high after release. Must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in  input  16 signed  peak value from PEAK; sampled every clk edge.
- alarm  output  1  high while state is ALARM or HOLD.
- state  output  2  current FSM state: IDLE=0, PENDING=1, ALARM=2, HOLD=3.
- events  output  16  count of IDLE/PENDING->ALARM entries; saturates at 16'hFFFF.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, alarm=0, events=0, internal counter cnt=0. Takes effect immediately, including mid-PENDING/ALARM/HOLD. First transition can occur on the first rising clk edge after rst returns high.
- Width rules:
  - Threshold compares are signed 16-bit.
  - cnt width is $clog2(max(DEBOUNCE,HOLD)+1).
  - events increments by 1 and never wraps.
- IDLE:
  - in >= HI_TH and DEBOUNCE==1: go to ALARM, events++.
  - in >= HI_TH otherwise: go to PENDING, cnt=1.
  - Else: stay.
- PENDING:
  - in < HI_TH: go to IDLE, cnt=0.
  - Else if cnt==DEBOUNCE-1: go to ALARM, events++.
  - Else: cnt++.
- ALARM:
  - in <= LO_TH: go to HOLD, cnt=0.
  - Samples strictly between LO_TH and HI_TH: stay in ALARM (hysteresis).
- HOLD:
  - in >= HI_TH: return to ALARM, events unchanged (retrigger).
  - Else if cnt==HOLD-1: go to IDLE.
  - Else: cnt++. Samples between the thresholds do not restart the timer.
- Latency:
  - alarm rises after the DEBOUNCE-th consecutive qualifying edge.
  - alarm falls exactly HOLD edges after the edge that entered HOLD, unless retriggered.
- alarm and state are decoded only from registered state; no combinational path from in to any output.
- Event saturation: at 16'hFFFF a further ALARM entry leaves events at 16'hFFFF.

Optional Feature:
- Macro PEAK_ALARM_ABS_EN.
- Defined: every compare uses magnitude |in|. -32768 saturates to 32767, so the magnitude stays in signed 16-bit range. Lets bipolar peaks trigger.
- Undefined: raw signed in is compared; negative values never assert.

Decomposition:
- types.v already provides the signed 16-bit reg/wire type macros; use them for in and internal registers.
- Add to the shared include: state encoding constants (PA_IDLE, PA_PENDING, PA_ALARM, PA_HOLD) and the 2-bit state type.
- One natural sub-module: alarm_timer. Loadable up-counter with clear, increment, and terminal-compare output, shared by the debounce and hold phases.

Test Plan (HI_TH=1000, LO_TH=500, DEBOUNCE=4, HOLD=8 unless noted):
- in=1200 for 3 cycles, then 0 -> state returns to IDLE; alarm never high; events=0.
- in=1200 held -> alarm=1 and events=1 after 4th edge. Then in=700 for 50 cycles -> alarm stays 1, state=ALARM.
- From ALARM, in=400 -> state=HOLD. alarm stays 1 for 8 edges, then alarm=0 and state=IDLE.
- In HOLD at cnt=5, in=1200 -> state=ALARM next edge, events stays 1. Then in=0 -> full 8-cycle hold restarts.
- rst pulled low mid-HOLD, between edges -> alarm=0, state=0, events=0 immediately, without waiting for a clk edge.
- DEBOUNCE=1, HOLD=1: toggle in 1200/0 for 65537 alarm entries -> events=16'hFFFF.
- ABS check, with PEAK_ALARM_ABS_EN: in=-1200 -> alarm; in=-32768 -> alarm.
- ABS check, without PEAK_ALARM_ABS_EN: in=-1200 -> no alarm.
